// File: rtl/bus_arbiter4.sv
// bus_arbiter4: round-robin arbiter sharing a 16-bit 4:1 mux among four requesters
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   req     request lines, held high for the whole transaction
//   gnt     one-hot grant (or zero), registered
//   sel     mux select, index of the current or most recent owner
//   busy    high while any grant is active
//   timeout one-cycle pulse when a grant is forcibly revoked
// Optional feature macro: ARB_TIMEOUT_EN (hold limit of MAX_HOLD cycles per grant).
// Without it, no hold counter exists and timeout stays 0.
module bus_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [1:0] last, w;
  logic revoke, rel;
  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_bad_param
    $error("bus_arbiter4: MAX_HOLD must be 1..255 and below 2**CNT_W");
  end
  // Lowest offset from the pointer wins; the pointer itself is searched last.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] v;
    v = p;
    for (int k = 4; k >= 1; k--)
      if (r[p + 2'(k)]) v = p + 2'(k);
    return v;
  endfunction
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  assign revoke = state == GRANT && req[sel] && cnt == CNT_W'(MAX_HOLD - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == IDLE || rel) ? '0 : cnt + 1'b1;
`else
  assign revoke = 1'b0;
`endif
  assign rel = state == GRANT && (!req[sel] || revoke);
  // On a release the owner becomes the new pointer, so search from sel.
  assign w = pick(req, state == IDLE ? last : sel);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      last    <= 2'd3;
    end else begin
      timeout <= revoke;
      if (state == IDLE ? |req : rel) begin
        if (state == GRANT) last <= sel;
        state <= |req ? GRANT : IDLE;
        gnt   <= |req ? 4'b0001 << w : 4'b0000;
        sel   <= |req ? w : sel;
        busy  <= |req;
      end
    end
endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed and random checks of bus_arbiter4 against a round-robin model
module tb_bus_arbiter4;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic busy, timeout;
  int checks = 0, errors = 0;
  int m_own, m_last, m_held;
  logic [1:0] m_sel;
  logic m_to;
  int order[$];
  int exp_ord[5] = '{0, 1, 2, 3, 0};
  logic [3:0] r;

  bus_arbiter4 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int search(input logic [3:0] rq, input int from);
    for (int k = 1; k <= 4; k++)
      if (rq[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_last = 3; m_held = 0; m_sel = 2'd0; m_to = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] rq);
    m_to = 1'b0;
    if (m_own < 0) begin
      m_own = search(rq, m_last);
      m_held = 1;
      if (m_own >= 0) m_sel = 2'(m_own);
    end else if (!rq[m_own] || (TO_EN && m_held >= MH)) begin
      m_to = rq[m_own];
      m_last = m_own;
      m_own = search(rq, m_last);
      m_held = 1;
      if (m_own >= 0) m_sel = 2'(m_own);
    end else m_held++;
  endtask

  task automatic chk(input string tag);
    logic [3:0] eg;
    eg = (m_own < 0) ? 4'b0000 : 4'b0001 << m_own;
    checks += 4;
    assert (gnt === eg) else begin errors++; $error("FAIL %s gnt got %b exp %b", tag, gnt, eg); end
    assert (sel === m_sel) else begin errors++; $error("FAIL %s sel got %0d exp %0d", tag, sel, m_sel); end
    assert (busy === (m_own >= 0)) else begin errors++; $error("FAIL %s busy got %b exp %b", tag, busy, m_own >= 0); end
    assert (timeout === m_to) else begin errors++; $error("FAIL %s timeout got %b exp %b", tag, timeout, m_to); end
  endtask

  task automatic step(input logic [3:0] rq, input string tag);
    req = rq;
    @(posedge clk);
    model_edge(rq);
    #1;
    chk(tag);
  endtask

  task automatic expect_gnt(input logic [3:0] eg, input string tag);
    checks++;
    assert (gnt === eg) else begin errors++; $error("FAIL %s gnt got %b exp %b", tag, gnt, eg); end
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(4'b0100, "single_grant");
    expect_gnt(4'b0100, "single_grant_const");
    step(4'b0000, "single_release");
    step(4'b0010, "own1");
    step(4'b1010, "no_preempt");
    expect_gnt(4'b0010, "no_preempt_const");
    step(4'b1000, "handover3");
    expect_gnt(4'b1000, "handover3_const");
    step(4'b0000, "idle_a");
    step(4'b0001, "own0");
    step(4'b0000, "last0");
    step(4'b1001, "pick3");
    expect_gnt(4'b1000, "pick3_const");
    step(4'b0001, "then0");
    expect_gnt(4'b0001, "then0_const");
    step(4'b0000, "idle_b");
    step(4'b0010, "pre_reset");
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset");
    #1 rst_n = 1'b1;
    step(4'b1111, "post_reset");
    expect_gnt(4'b0001, "post_reset_const");
    order.push_back(m_own);
    for (int s = 0; s < 60 && order.size() < 5; s++) begin
      r = (m_own >= 0 && m_held >= 3) ? 4'b1111 & ~(4'b0001 << m_own) : 4'b1111;
      step(r, "rotate");
      if (m_own >= 0 && order[$] != m_own) order.push_back(m_own);
    end
    checks++;
    assert (order.size() == 5) else begin errors++; $error("FAIL rotate_len got %0d exp 5", order.size()); end
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      checks++;
      assert (order[i] === exp_ord[i]) else begin errors++; $error("FAIL rotate_order[%0d] got %0d exp %0d", i, order[i], exp_ord[i]); end
    end
    step(4'b0000, "idle_c");
    step(4'b0000, "idle_d");
    for (int s = 0; s < 10; s++) step(4'b0011, "hold_pair");
    for (int s = 0; s < 10; s++) step(4'b0001, "hold_solo");
    step(4'b0000, "idle_e");
    for (int s = 0; s < 400; s++) begin
      r = 4'($urandom);
      if (m_own >= 0 && $urandom_range(0, 3) != 0) r[m_own] = 1'b1;
      step(r, "random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter4.md
Name: bus_arbiter4

Overview:
- Round-robin arbiter that shares one 16-bit datapath resource among four requesters.
- Typical resource: a shared operand or writeback bus fed through a 4:1 16-bit mux.
- Generates the 2-bit mux select plus one-hot grants, sequenced by a small state machine.
- Sits between requesting units (PC logic, ALU, memory, immediate unit) and the 4:1 mux select input.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles a single grant may be held. Used only with ARB_TIMEOUT_EN. Legal range 1..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST_N  input  1  asynchronous, active-low reset.
- REQ  input  4  request lines. REQ[i] high means requester i wants the resource; held high for the whole transaction.
- GNT  output  4  one-hot grant, or all zero. GNT[i] means requester i currently owns the resource.
- SEL  output  2  mux select; equals the index of the current or most recent owner.
- BUSY  output  1  high while any grant is active.
- TIMEOUT  output  1  one-cycle pulse when a grant is forcibly revoked (ARB_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Interface: one clock CLK. RST_N is asynchronous and active-low.
- Reset values: GNT=4'b0000, SEL=2'd0, BUSY=0, TIMEOUT=0, state=IDLE, last-owner pointer LAST=2'd3 (first arbitration favours requester 0), hold counter=0.
- All outputs are registered; none depends combinationally on REQ.
- Priority order: the search starts at (LAST+1) mod 4 and proceeds upward with wrap-around. The first requester found with REQ set wins.
- State IDLE (GNT=0, BUSY=0):
  - If REQ is nonzero at a rising edge, go to GRANT at that edge.
  - GNT[w]=1, SEL=w, BUSY=1, with w the winner. Grant latency: 1 cycle after REQ is sampled.
- State GRANT:
  - Ownership holds while REQ[SEL]=1. Requests from other requesters are ignored; no preemption.
  - Release: REQ[SEL] sampled 0. At that edge LAST<=SEL.
    - If any other REQ bit is set, the new winner is granted at the same edge. The old grant drops and the new one rises with zero idle cycles, so no cycle has two GNT bits set.
    - Otherwise go to IDLE. GNT=0 and BUSY=0; SEL keeps its value so the mux output stays deterministic.
- Re-request: a requester that drops REQ for exactly one cycle and raises it again competes normally, at lowest priority relative to the others.
- REQ=4'b1111 continuously, with each owner holding for N cycles then releasing: grants rotate 0,1,2,3,0,...
- Invariants:
  - GNT is always one-hot or zero.
  - BUSY = |GNT.
  - SEL is changed only on a new grant or by reset.
- Reset mid-grant: RST_N low forces all reset values immediately (asynchronously), independent of CLK. The first post-reset grant favours requester 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter clears on every new grant and increments each cycle in GRANT.
  - When the counter equals MAX_HOLD-1 and the owner still requests, the grant is revoked at the next edge. At that edge TIMEOUT=1 for one cycle and LAST<=SEL, then re-arbitration runs as on a normal release.
  - The revoked owner can be re-granted immediately only if no other requester is pending.
  - With MAX_HOLD=16, a single owner holds for at most 16 cycles.
- Undefined:
  - No counter is instantiated and TIMEOUT is tied to 0.
  - Grants are held indefinitely while REQ[SEL]=1.

Test Plan:
- Reset then REQ=4'b0100 -> one cycle later GNT=4'b0100, SEL=2, BUSY=1. REQ=0 -> next edge GNT=0, BUSY=0, SEL stays 2.
- REQ=4'b1111, each owner releases after 3 cycles and re-raises one cycle later -> grant order 0,1,2,3,0. Handover has no idle cycle and never shows two GNT bits set.
- Owner 1 holding, REQ[3] raised -> no preemption. Owner 1 drops REQ -> GNT=4'b1000 at the same edge.
- Simultaneous REQ=4'b1001 with LAST=0 -> requester 3 granted. Requester 3 then releases -> requester 0 granted.
- RST_N pulsed low mid-grant (GNT=4'b0010) -> GNT=0, SEL=0, BUSY=0 immediately without a clock. Afterwards REQ=4'b1111 -> requester 0 granted first.
- ARB_TIMEOUT_EN, MAX_HOLD=4, REQ=4'b0011 with 0 never releasing:
  - Owner 0 is revoked after 4 cycles, with a one-cycle TIMEOUT pulse, and GNT=4'b0010.
  - With REQ[1] low instead, 0 is re-granted at once and TIMEOUT still pulses.
